port_arbiter: RTL and testbench

PORT_ARBITER -- requirements
Module: port_arbiter

---
 rtl/pgnoc_pkg.sv | 17 +
 rtl/rr_pick.sv | 34 +++
 rtl/port_arbiter.sv | 96 +++++++++
 tb/tb_port_arbiter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/pgnoc_pkg.sv
// Shared NoC definitions: arbiter state encoding and a width helper.
package pgnoc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Ceiling log2 with a floor of 1 so single-entry indices still get a bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requesting port at or after ptr, wrapping past PORTS_NUM.
module rr_pick
    import pgnoc_pkg::*;
#(
    parameter int unsigned PORTS_NUM = 4,
    localparam int unsigned IDX_W    = clog2(PORTS_NUM + 1)
) (
    input  logic [PORTS_NUM:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    int unsigned off;
    int unsigned cand;

    // Scan offsets from largest to smallest so the nearest requester wins last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        off   = 0;
        cand  = 0;
        for (int unsigned k = 0; k <= PORTS_NUM; k++) begin
            off  = PORTS_NUM - k;
            cand = 32'(ptr) + off;
            if (cand > PORTS_NUM) cand = cand - (PORTS_NUM + 1);
            if (req[IDX_W'(cand)]) begin
                found = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/port_arbiter.sv
// Burst-limited round-robin arbiter feeding a single downstream write buffer.
module port_arbiter
    import pgnoc_pkg::*;
#(
    parameter int unsigned PORTS_NUM = 4,
    parameter int unsigned BURST_LEN = 4,
    localparam int unsigned IDX_W    = clog2(PORTS_NUM + 1)
) (
    input  logic               clk,
    input  logic               a_rst,
    input  logic [PORTS_NUM:0] req,
    input  logic               is_full,
    output logic [PORTS_NUM:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic [PORTS_NUM:0] ack,
    output logic               wr_req
);

    localparam int unsigned NP = PORTS_NUM + 1;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]       burst_cnt_q, burst_cnt_d;
    logic [NP-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;

    logic [IDX_W-1:0] nxt_ptr;
    logic [IDX_W-1:0] pick_ptr;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             xfer;
    logic             release_c;

    assign ack    = grant_q & req & {NP{~is_full}};
    assign wr_req = |ack;
    assign xfer   = wr_req;

    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;

    assign nxt_ptr   = (grant_idx_q == IDX_W'(PORTS_NUM)) ? '0 : grant_idx_q + IDX_W'(1);
    // While busy the picker only matters on release, where it searches past the current owner.
    assign pick_ptr  = (state_q == BUSY) ? nxt_ptr : rr_ptr_q;
    assign release_c = (state_q == BUSY) &&
                       (!req[grant_idx_q] || (xfer && burst_cnt_q == 8'(BURST_LEN - 1)));

    rr_pick #(
        .PORTS_NUM(PORTS_NUM)
    ) u_pick (
        .req  (req),
        .ptr  (pick_ptr),
        .found(pick_found),
        .idx  (pick_idx)
    );

    // Next-state: grant on pick, count transfers, hand over on release.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        if (state_q == IDLE || release_c) begin
            if (release_c) rr_ptr_d = nxt_ptr;
            burst_cnt_d = 8'd0;
            if (pick_found) begin
                state_d     = BUSY;
                grant_d     = NP'(1) << pick_idx;
                grant_idx_d = pick_idx;
            end else begin
                state_d     = IDLE;
                grant_d     = '0;
                grant_idx_d = '0;
            end
        end else if (xfer) begin
            burst_cnt_d = burst_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            burst_cnt_q <= 8'd0;
            grant_q     <= '0;
            grant_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
        end
    end

endmodule

// File: tb/tb_port_arbiter.sv
// Directed vector bench for port_arbiter with PORTS_NUM = 4, BURST_LEN = 4.
module tb_port_arbiter;

    logic       clk;
    logic       a_rst;
    logic [4:0] req;
    logic       is_full;
    logic [4:0] grant;
    logic [2:0] grant_idx;
    logic [4:0] ack;
    logic       wr_req;

    int n_checks;
    int n_errors;

    typedef struct {
        logic       rst_n;
        logic [4:0] req;
        logic       full;
        logic [4:0] grant;
        logic [2:0] idx;
        logic [4:0] ack;
        logic       wr;
    } vec_t;

    vec_t vecs[$];

    port_arbiter #(
        .PORTS_NUM(4),
        .BURST_LEN(4)
    ) dut (
        .clk      (clk),
        .a_rst    (a_rst),
        .req      (req),
        .is_full  (is_full),
        .grant    (grant),
        .grant_idx(grant_idx),
        .ack      (ack),
        .wr_req   (wr_req)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic add(input logic rst_n, input logic [4:0] rq, input logic full,
                       input logic [4:0] g, input logic [2:0] i, input logic [4:0] ak,
                       input logic w, input int n);
        vec_t v;
        v.rst_n = rst_n; v.req = rq; v.full = full;
        v.grant = g; v.idx = i; v.ack = ak; v.wr = w;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        a_rst    = 1'b0;
        req      = '0;
        is_full  = 1'b0;

        // Each row is one cycle: inputs, then expected state seen during that cycle.
        // Reset holds everything low regardless of inputs.
        add(0, 5'b11111, 0, 5'b00000, 3'd0, 5'b00000, 0, 1);
        add(0, 5'b00000, 0, 5'b00000, 3'd0, 5'b00000, 0, 1);
        add(1, 5'b00000, 0, 5'b00000, 3'd0, 5'b00000, 0, 1);
        // Sole requester: one-cycle latency then back-to-back re-grants.
        add(1, 5'b00100, 0, 5'b00000, 3'd0, 5'b00000, 0, 1);
        add(1, 5'b00100, 0, 5'b00100, 3'd2, 5'b00100, 1, 9);
        add(1, 5'b00000, 0, 5'b00100, 3'd2, 5'b00000, 0, 1);
        add(1, 5'b00000, 0, 5'b00000, 3'd0, 5'b00000, 0, 1);
        // Reset to bring rr_ptr back to 0, then full round-robin rotation.
        add(0, 5'b00000, 0, 5'b00000, 3'd0, 5'b00000, 0, 1);
        add(1, 5'b00000, 0, 5'b00000, 3'd0, 5'b00000, 0, 1);
        add(1, 5'b11111, 0, 5'b00000, 3'd0, 5'b00000, 0, 1);
        add(1, 5'b11111, 0, 5'b00001, 3'd0, 5'b00001, 1, 4);
        add(1, 5'b11111, 0, 5'b00010, 3'd1, 5'b00010, 1, 4);
        add(1, 5'b11111, 0, 5'b00100, 3'd2, 5'b00100, 1, 4);
        add(1, 5'b11111, 0, 5'b01000, 3'd3, 5'b01000, 1, 4);
        add(1, 5'b11111, 0, 5'b10000, 3'd4, 5'b10000, 1, 4);
        add(1, 5'b11111, 0, 5'b00001, 3'd0, 5'b00001, 1, 1);
        // Reset mid-burst aborts the grant at once; next grant searches from 0.
        add(0, 5'b00000, 0, 5'b00000, 3'd0, 5'b00000, 0, 1);
        add(1, 5'b00010, 0, 5'b00000, 3'd0, 5'b00000, 0, 1);
        // Backpressure after two transfers, then finish the burst and hand over.
        add(1, 5'b01010, 0, 5'b00010, 3'd1, 5'b00010, 1, 2);
        add(1, 5'b01010, 1, 5'b00010, 3'd1, 5'b00000, 0, 3);
        add(1, 5'b01010, 0, 5'b00010, 3'd1, 5'b00010, 1, 2);
        // Port 3 owns; a non-granted port changing has no effect; drop wraps to 0.
        add(1, 5'b01001, 0, 5'b01000, 3'd3, 5'b01000, 1, 1);
        add(1, 5'b00001, 0, 5'b01000, 3'd3, 5'b00000, 0, 1);
        add(1, 5'b00001, 0, 5'b00001, 3'd0, 5'b00001, 1, 1);
        // Owner drops while full: release still happens.
        add(1, 5'b00000, 1, 5'b00001, 3'd0, 5'b00000, 0, 1);
        add(1, 5'b00000, 0, 5'b00000, 3'd0, 5'b00000, 0, 1);

        #1;
        foreach (vecs[r]) begin
            a_rst   = vecs[r].rst_n;
            req     = vecs[r].req;
            is_full = vecs[r].full;
            @(negedge clk);
            chk("grant",     r, 8'(grant),     8'(vecs[r].grant));
            chk("grant_idx", r, 8'(grant_idx), 8'(vecs[r].idx));
            chk("ack",       r, 8'(ack),       8'(vecs[r].ack));
            chk("wr_req",    r, 8'(wr_req),    8'(vecs[r].wr));
            @(posedge clk);
            #1;
        end

        // Hand sequence: rr_ptr is now 1, so an all-request grant goes to port 1.
        req = 5'b11111;
        @(posedge clk); #1;
        chk("seq_grant_idx", 100, 8'(grant_idx), 8'd1);
        chk("seq_wr_req",    100, 8'(wr_req),    8'd1);
        // Reset between edges must clear outputs without a clock edge.
        #2 a_rst = 1'b0;
        #1;
        chk("async_grant",  101, 8'(grant),     8'd0);
        chk("async_idx",    101, 8'(grant_idx), 8'd0);
        chk("async_ack",    101, 8'(ack),       8'd0);
        chk("async_wr_req", 101, 8'(wr_req),    8'd0);
        @(posedge clk); #1;
        chk("inrst_grant",  102, 8'(grant),     8'd0);
        a_rst = 1'b1;
        req   = 5'b00010;
        @(negedge clk);
        chk("post_rst_latency", 103, 8'(grant), 8'd0);
        @(posedge clk); #1;
        chk("post_rst_idx",   104, 8'(grant_idx), 8'd1);
        chk("post_rst_grant", 104, 8'(grant),     8'b00010);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
